md_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the forwarded ALU operands, i.e. the outputs of the operand-A and operand-B forwarding muxes. It owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo. It raises a stall request to the hazard unit while a result is pending.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_core_calc.sv | 75 +++++++
 rtl/md_unit.sv | 119 +++++++++++
 tb/tb_md_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM states and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W_DEF       = 4;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_multi(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_core_calc.sv
// Combinational 64-bit {hi,lo} result generator for mult/multu/div/divu.
// result_ok is low for a divide by zero, meaning HI/LO must not change.
module md_core_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        result_ok
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] uquo;
  logic [31:0] urem;
  logic        div_zero;

  // Low 64 bits of a 64x64 product equal the signed 32x32 product when
  // the operands are sign-extended, so one multiplier serves both forms.
  always_comb begin
    ext_a = {32'h0, src_a};
    ext_b = {32'h0, src_b};
    if (op == MD_MULT) begin
      ext_a = {{32{src_a[31]}}, src_a};
      ext_b = {{32{src_b[31]}}, src_b};
    end
    product = ext_a * ext_b;
  end

  // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps to
  // 0x80000000 with remainder 0 without any special case.
  always_comb begin
    div_zero = (src_b == 32'h0);
    neg_a    = (op == MD_DIV) && src_a[31];
    neg_b    = (op == MD_DIV) && src_b[31];
    mag_a    = neg_a ? (~src_a + 32'd1) : src_a;
    mag_b    = neg_b ? (~src_b + 32'd1) : src_b;
    quo_mag  = 32'h0;
    rem_mag  = 32'h0;
    if (!div_zero) begin
      quo_mag = mag_a / mag_b;
      rem_mag = mag_a % mag_b;
    end
    uquo = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
    urem = neg_a ? (~rem_mag + 32'd1) : rem_mag;
  end

  always_comb begin
    result    = 64'h0;
    result_ok = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        result    = product;
        result_ok = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        result    = {urem, uquo};
        result_ok = !div_zero;
      end
      default: begin
        result    = 64'h0;
        result_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO; holds results in a
// pending register for a fixed latency and requests stalls while busy.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = MD_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  input  logic [2:0]  MDOp_E,
  input  logic        Start_E,
  input  logic        Flush_E,
  input  logic        MDUse_D,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Stall_MD,
  output md_state_e   dbg_state
);

  // Handshake: an op is taken on a rising edge when Start_E=1, Flush_E=0 and
  // the unit is idle; Busy/Stall_MD hold the pipeline until HI/LO commit.

  md_state_e       state_q;
  md_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]     pend_q;
  logic            pend_ok_q;
  logic [2:0]      op_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;

  logic [63:0]     calc_result;
  logic            calc_ok;
  logic            accept;
  logic            multi_op;
  logic            done;

  md_core_calc u_calc (
    .op        (MDOp_E),
    .src_a     (SrcA_E),
    .src_b     (SrcB_E),
    .result    (calc_result),
    .result_ok (calc_ok)
  );

  assign multi_op = md_is_multi(MDOp_E);
  assign accept   = Start_E && !Flush_E && (state_q == ST_IDLE);
  assign done     = (state_q == ST_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && multi_op) state_d = ST_BUSY;
      ST_BUSY: if (done)               state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, pending result and latched op for the multi-cycle path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pend_q    <= 64'h0;
      pend_ok_q <= 1'b0;
      op_q      <= MD_NONE;
    end else if (accept && multi_op) begin
      pend_q    <= calc_result;
      pend_ok_q <= calc_ok;
      op_q      <= MDOp_E;
      if ((MDOp_E == MD_MULT) || (MDOp_E == MD_MULTU)) begin
        cnt_q <= CNT_W'(MULT_CYCLES - 1);
      end else begin
        cnt_q <= CNT_W'(DIV_CYCLES - 1);
      end
    end else if (state_q == ST_BUSY) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        op_q <= MD_NONE;
      end
    end
  end

  // A divide by zero completes its busy period but leaves HI/LO alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else if (done) begin
      if (pend_ok_q) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
    end else if (accept) begin
      if (MDOp_E == MD_MTHI) hi_q <= SrcA_E;
      if (MDOp_E == MD_MTLO) lo_q <= SrcA_E;
    end
  end

  assign HI        = hi_q;
  assign LO        = lo_q;
  assign Busy      = (state_q == ST_BUSY);
  assign Stall_MD  = MDUse_D && (Busy || (Start_E && !Flush_E && multi_op));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO come from an independent
// 64-bit integer model and are queued at issue, compared at commit.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] SrcA_E;
  logic [31:0] SrcB_E;
  logic [2:0]  MDOp_E;
  logic        Start_E;
  logic        Flush_E;
  logic        MDUse_D;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Stall_MD;
  md_state_e   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_hl;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .SrcA_E    (SrcA_E),
    .SrcB_E    (SrcB_E),
    .MDOp_E    (MDOp_E),
    .Start_E   (Start_E),
    .Flush_E   (Flush_E),
    .MDUse_D   (MDUse_D),
    .HI        (HI),
    .LO        (LO),
    .Busy      (Busy),
    .Stall_MD  (Stall_MD),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa;
    longint          sb;
    longint          sq;
    longint          sr;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd1: begin sq = sa * sb; return sq; end
      3'd2: begin up = ua * ub; return up; end
      3'd3: begin
        if (b == 32'h0) return cur;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'h0) return cur;
        up = ua / ub;
        ua = ua % ub;
        return {ua[31:0], up[31:0]};
      end
      default: return cur;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush, input logic exp_stall);
    @(negedge clk);
    SrcA_E  = a;
    SrcB_E  = b;
    MDOp_E  = op;
    Start_E = 1'b1;
    Flush_E = flush;
    #1 check("stall_accept", Stall_MD, exp_stall);
    @(posedge clk);
    #1;
    Start_E = 1'b0;
    Flush_E = 1'b0;
    MDOp_E  = 3'd0;
  endtask

  task automatic run_multi(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic use_d);
    logic [63:0] exp;
    int n;
    int busy_cnt;
    exp = model(op, a, b, cur_hl);
    exp_q.push_back(exp);
    cur_hl = exp;
    n = (op <= 3'd2) ? 5 : 10;
    MDUse_D = use_d;
    issue(op, a, b, 1'b0, use_d);
    busy_cnt = 0;
    @(negedge clk);
    while (Busy && busy_cnt < 40) begin
      busy_cnt++;
      check("stall_busy", Stall_MD, use_d);
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, n);
    MDUse_D = 1'b1;
    #1 check("stall_after", Stall_MD, 1'b0);
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      check("hilo", {HI, LO}, exp_q.pop_front());
    end
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    issue(op, a, 32'h0, 1'b0, 1'b0);
    if (op == 3'd5) cur_hl[63:32] = a;
    else            cur_hl[31:0]  = a;
    @(negedge clk);
    check("mt_hilo", {HI, LO}, cur_hl);
    check("mt_busy", Busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    SrcA_E  = 32'h0;
    SrcB_E  = 32'h0;
    MDOp_E  = 3'd0;
    Start_E = 1'b0;
    Flush_E = 1'b0;
    MDUse_D = 1'b1;
    cur_hl  = 64'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_hilo", {HI, LO}, 64'h0);
    check("reset_busy", Busy, 1'b0);
    check("reset_stall", Stall_MD, 1'b0);

    run_multi(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
    run_multi(3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    check("multu_const", {HI, LO}, 64'h00000001_FFFFFFFE);
    run_multi(3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1);
    check("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_multi(3'd4, 32'h00000007, 32'h00000002, 1'b1);
    check("divu_const", {HI, LO}, 64'h00000001_00000003);

    run_mt(3'd5, 32'h00000011);
    run_mt(3'd6, 32'h00000022);
    run_multi(3'd3, 32'h00000005, 32'h00000000, 1'b0);
    check("divzero_const", {HI, LO}, 64'h00000011_00000022);

    MDUse_D = 1'b1;
    issue(3'd1, 32'h3, 32'h4, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_busy", Busy, 1'b0);
    check("flush_hilo", {HI, LO}, 64'h00000011_00000022);

    run_multi(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);

    run_mt(3'd5, 32'hDEADBEEF);
    check("mthi_const", {HI, LO}, 64'hDEADBEEF_80000000);

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
      run_multi(op, a, b, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a mult abandons it.
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("mid_busy_before", Busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_busy", Busy, 1'b0);
    check("mid_reset_hilo", {HI, LO}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cur_hl  = 64'h0;
    repeat (8) @(negedge clk);
    check("mid_no_commit", {HI, LO}, 64'h0);
    check("mid_idle", Busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
